trdb_packet_unpacker: RTL and testbench

Receive-side counterpart of the trace debugger packet output. Accepts the bit-packed 32-bit word stream emitted by the trace debugger, splits it into length-prefixed trace packets, and presents each packet zero-extended to 128 bits with its decoded header fields. It is used in the testbench and in on-chip loopback paths to recover packets for the golden-model comparison.

---
 rtl/trdb_pkg.sv | 31 +++
 rtl/trdb_packet_unpacker_if.sv | 28 ++
 rtl/trdb_bitbuf.sv | 55 +++++
 rtl/trdb_packet_unpacker.sv | 143 ++++++++++++++
 tb/tb_trdb_packet_unpacker.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trdb_pkg.sv
// Shared trace-debugger types and constants for the packet unpacker.
package trdb_pkg;

  localparam int unsigned TRDB_PKT_W  = 128;
  localparam int unsigned TRDB_LEN_W  = 7;
  localparam int unsigned TRDB_WORD_W = 32;
  localparam int unsigned TRDB_BUF_W  = 160;
  localparam int unsigned TRDB_FILL_W = 8;
  localparam int unsigned TRDB_POS_W  = 5;

  typedef enum logic [1:0] {
    TRDB_MSG_RSVD  = 2'd0,
    TRDB_MSG_SW    = 2'd1,
    TRDB_MSG_TIMER = 2'd2,
    TRDB_MSG_TRACE = 2'd3
  } trdb_msgtype_e;

  typedef logic [1:0] trdb_format_t;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_PAY = 2'd1,
    S_OUT = 2'd2
  } trdb_unpack_state_e;

  // Mask keeping the low len bits of a packet payload.
  function automatic logic [TRDB_PKT_W-1:0] trdb_len_mask(input logic [TRDB_LEN_W-1:0] len);
    return (TRDB_PKT_W'(1) << len) - TRDB_PKT_W'(1);
  endfunction

endpackage

// File: rtl/trdb_packet_unpacker_if.sv
// Word-stream input and packet output bundle of the trace packet unpacker.
//   word_*   : 32-bit packed stream, valid/ready
//   packet_* : decoded packet with header fields, valid/ready
// slave  : unpacker side; master : stream producer / packet consumer side.
interface trdb_packet_unpacker_if;
  import trdb_pkg::*;

  logic [TRDB_WORD_W-1:0] word_i;
  logic                   word_valid_i;
  logic                   word_ready_o;
  logic [TRDB_PKT_W-1:0]  packet_o;
  logic [TRDB_LEN_W-1:0]  packet_len_o;
  trdb_msgtype_e          msgtype_o;
  trdb_format_t           format_o;
  logic                   packet_valid_o;
  logic                   packet_ready_i;

  modport slave (
    input  word_i, word_valid_i, packet_ready_i,
    output word_ready_o, packet_o, packet_len_o, msgtype_o, format_o, packet_valid_o
  );

  modport master (
    output word_i, word_valid_i, packet_ready_i,
    input  word_ready_o, packet_o, packet_len_o, msgtype_o, format_o, packet_valid_o
  );

endinterface

// File: rtl/trdb_bitbuf.sv
// 160-bit LSB-first shift buffer: per cycle, consume 0..127 bits from the
// bottom, then optionally append one 32-bit word at the new fill level.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   flush_i       : drop all buffered bits
//   append_i      : append word_i this cycle
//   consume_i     : bits removed from the bottom this cycle (<= fill_o)
//   fill_o        : number of valid bits held
//   data_o        : lowest 128 buffered bits (bits above fill_o are 0)
module trdb_bitbuf
  import trdb_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   append_i,
  input  logic [TRDB_WORD_W-1:0] word_i,
  input  logic [TRDB_LEN_W-1:0]  consume_i,
  output logic [TRDB_FILL_W-1:0] fill_o,
  output logic [TRDB_PKT_W-1:0]  data_o
);

  logic [TRDB_BUF_W-1:0]  bits_q, bits_d, shifted;
  logic [TRDB_FILL_W-1:0] fill_q, fill_d, fill_after;

  // Shift out consumed bits first, then OR the new word in above the survivors;
  // bits above fill are kept zero so the OR is a clean insert.
  always_comb begin
    shifted    = bits_q >> consume_i;
    fill_after = fill_q - TRDB_FILL_W'(consume_i);
    bits_d     = shifted;
    fill_d     = fill_after;
    if (append_i) begin
      bits_d = shifted | (TRDB_BUF_W'(word_i) << fill_after);
      fill_d = fill_after + TRDB_FILL_W'(TRDB_WORD_W);
    end
    if (flush_i) begin
      bits_d = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bits_q <= '0;
      fill_q <= '0;
    end else begin
      bits_q <= bits_d;
      fill_q <= fill_d;
    end
  end

  assign fill_o = fill_q;
  assign data_o = bits_q[TRDB_PKT_W-1:0];

endmodule

// File: rtl/trdb_packet_unpacker.sv
// Splits the bit-packed trace word stream into length-prefixed packets and
// presents each one zero-extended with its msgtype/format fields.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   flush_i       : drop buffered bits and any pending packet
//   bus (slave)   : word_i/word_valid_i/word_ready_o stream in,
//                   packet_o/packet_len_o/msgtype_o/format_o/packet_valid_o/
//                   packet_ready_i packet out
module trdb_packet_unpacker
  import trdb_pkg::*;
#(
  parameter int unsigned WORD_W = TRDB_WORD_W,
  parameter int unsigned PKT_W  = TRDB_PKT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  trdb_packet_unpacker_if.slave bus
);

  localparam int unsigned HdrBits = TRDB_LEN_W;

  trdb_unpack_state_e     state_q, state_d;
  logic [TRDB_LEN_W-1:0]  len_q, len_d;
  logic [TRDB_LEN_W-1:0]  plen_q, plen_d;
  logic [PKT_W-1:0]       packet_q, packet_d, payload_c;
  trdb_msgtype_e          msg_q, msg_d;
  trdb_format_t           fmt_q, fmt_d;
  logic                   valid_q, valid_d;
  logic [TRDB_POS_W-1:0]  pos_q, pos_d, hdr_end_c, pad_c;

  logic [TRDB_FILL_W-1:0] fill;
  logic [TRDB_PKT_W-1:0]  bb_data;
  logic [TRDB_LEN_W-1:0]  consume_c, hdr_len_c;
  logic [WORD_W-1:0]      word_c;
  logic                   word_ready_c, append_c;

  // Room check uses registered fill only, so acceptance is independent of FSM state.
  assign word_ready_c = rst_ni & ~flush_i & (fill <= TRDB_FILL_W'(128));
  assign append_c     = bus.word_valid_i & word_ready_c;
  assign word_c       = WORD_W'(bus.word_i);

  trdb_bitbuf u_bitbuf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .append_i  (append_c),
    .word_i    (TRDB_WORD_W'(word_c)),
    .consume_i (consume_c),
    .fill_o    (fill),
    .data_o    (bb_data)
  );

  // Padding skips from the end of the zero header to the next word boundary.
  assign hdr_end_c = pos_q + TRDB_POS_W'(HdrBits);
  assign pad_c     = TRDB_POS_W'(0) - hdr_end_c;
  assign hdr_len_c = bb_data[TRDB_LEN_W-1:0];
  assign payload_c = PKT_W'(bb_data & trdb_len_mask(len_q));

  // Next-state, consumption and output-register update.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    plen_d    = plen_q;
    packet_d  = packet_q;
    msg_d     = msg_q;
    fmt_d     = fmt_q;
    valid_d   = valid_q;
    consume_c = '0;

    unique case (state_q)
      S_HDR: begin
        if (fill >= TRDB_FILL_W'(HdrBits)) begin
          if (hdr_len_c != '0) begin
            consume_c = TRDB_LEN_W'(HdrBits);
            len_d     = hdr_len_c;
            state_d   = S_PAY;
          end else if (fill >= TRDB_FILL_W'(HdrBits) + TRDB_FILL_W'(pad_c)) begin
            // Header and realignment are dropped together, never one without the other.
            consume_c = TRDB_LEN_W'(HdrBits) + TRDB_LEN_W'(pad_c);
            len_d     = '0;
          end
        end
      end
      S_PAY: begin
        if (fill >= TRDB_FILL_W'(len_q)) begin
          consume_c = len_q;
          packet_d  = payload_c;
          plen_d    = len_q;
          msg_d     = trdb_msgtype_e'(payload_c[1:0]);
          fmt_d     = payload_c[3:2];
          valid_d   = 1'b1;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.packet_ready_i) begin
          valid_d = 1'b0;
          state_d = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase

    if (flush_i) begin
      consume_c = '0;
      valid_d   = 1'b0;
      state_d   = S_HDR;
    end
  end

  // Offset inside the oldest word is total consumption modulo the word size.
  assign pos_d = flush_i ? '0 : pos_q + TRDB_POS_W'(consume_c);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_HDR;
      len_q    <= '0;
      plen_q   <= '0;
      packet_q <= '0;
      msg_q    <= TRDB_MSG_RSVD;
      fmt_q    <= '0;
      valid_q  <= 1'b0;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      plen_q   <= plen_d;
      packet_q <= packet_d;
      msg_q    <= msg_d;
      fmt_q    <= fmt_d;
      valid_q  <= valid_d;
      pos_q    <= pos_d;
    end
  end

  assign bus.word_ready_o   = word_ready_c;
  assign bus.packet_o       = TRDB_PKT_W'(packet_q);
  assign bus.packet_len_o   = plen_q;
  assign bus.msgtype_o      = msg_q;
  assign bus.format_o       = fmt_q;
  assign bus.packet_valid_o = valid_q;

endmodule

// File: tb/tb_trdb_packet_unpacker.sv
// Bench for trdb_packet_unpacker: streams are built as bit lists from packet
// descriptions, packed into words, and decoded packets are compared in order.
module tb_trdb_packet_unpacker;
  import trdb_pkg::*;

  typedef struct packed {
    logic [6:0]   len;
    logic [1:0]   msg;
    logic [1:0]   fmt;
    logic [127:0] data;
  } pkt_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   failures;

  bit          bits_q[$];
  logic [31:0] words_q[$];
  pkt_t        exp_q[$];
  pkt_t        rx_q[$];
  int          rx_cyc_q[$];

  trdb_packet_unpacker_if bus ();

  trdb_packet_unpacker dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic stream_clear();
    bits_q.delete();
    words_q.delete();
    exp_q.delete();
    rx_q.delete();
    rx_cyc_q.delete();
  endtask

  // Append one packet (header + masked payload) and record it as expected.
  task automatic add_pkt(input int len, input logic [127:0] data);
    pkt_t p;
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < len; i++) m[i] = data[i];
    for (int i = 0; i < 7; i++) bits_q.push_back(len[i]);
    for (int i = 0; i < len; i++) bits_q.push_back(m[i]);
    p.len  = 7'(len);
    p.data = m;
    p.msg  = m[1:0];
    p.fmt  = m[3:2];
    exp_q.push_back(p);
  endtask

  // Zero header, then junk up to the next word boundary (must be discarded).
  task automatic add_pad();
    for (int i = 0; i < 7; i++) bits_q.push_back(1'b0);
    while ((bits_q.size() % 32) != 0) bits_q.push_back(1'($urandom_range(1)));
  endtask

  task automatic build_words();
    logic [31:0] w;
    int n;
    n = bits_q.size();
    for (int i = 0; i < n; i += 32) begin
      w = '0;
      for (int b = 0; b < 32; b++) if (i + b < n) w[b] = bits_q[i + b];
      words_q.push_back(w);
    end
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    bus.word_valid_i   = 1'b0;
    bus.packet_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Feed words_q and collect packets until all expected packets arrive.
  task automatic run_stream(input int max_cycles, input int ready_pct, output bit to);
    int cyc;
    cyc = 0;
    while ((words_q.size() != 0 || rx_q.size() < exp_q.size()) && cyc < max_cycles) begin
      @(negedge clk);
      bus.word_valid_i   = (words_q.size() != 0);
      bus.word_i         = (words_q.size() != 0) ? words_q[0] : $urandom();
      bus.packet_ready_i = ($urandom_range(99) < ready_pct);
      if (bus.word_valid_i && bus.word_ready_o) void'(words_q.pop_front());
      if (bus.packet_valid_o && bus.packet_ready_i) begin
        rx_q.push_back({bus.packet_len_o, 2'(bus.msgtype_o), bus.format_o, bus.packet_o});
        rx_cyc_q.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    bus.word_valid_i   = 1'b0;
    bus.packet_ready_i = 1'b0;
    to = (cyc >= max_cycles);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    bus.word_valid_i   = 1'b0;
    bus.word_i         = '0;
    bus.packet_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.word_ready_o !== 1'b0 || bus.packet_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl ready=%b valid=%b want 0 0", bus.word_ready_o, bus.packet_valid_o);
    end
    checks++;
    if (bus.packet_o !== '0 || bus.packet_len_o !== '0 || bus.msgtype_o !== 2'd0 || bus.format_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs pkt=%h len=%0d msg=%0d fmt=%0d want all 0",
               bus.packet_o, bus.packet_len_o, bus.msgtype_o, bus.format_o);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.word_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b want 1", bus.word_ready_o);
    end
  endtask

  task automatic test_single();
    logic [31:0] w;
    do_flush();
    w = 32'd20 | (32'h000A_BCDE << 7);
    @(negedge clk);
    bus.word_i = w;
    bus.word_valid_i = 1'b1;
    checks++;
    if (bus.word_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL single_accept ready=%b want 1", bus.word_ready_o);
    end
    @(posedge clk);
    @(negedge clk);
    bus.word_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.packet_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_early valid=%b want 0 one edge after accept", bus.packet_valid_o);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.packet_valid_o !== 1'b1 || bus.packet_len_o !== 7'd20 || bus.packet_o !== 128'hABCDE ||
        bus.msgtype_o !== 2'd2 || bus.format_o !== 2'd3) begin
      failures++;
      $display("FAIL single_pkt valid=%b len=%0d pkt=%h msg=%0d fmt=%0d want 1 20 abcde 2 3",
               bus.packet_valid_o, bus.packet_len_o, bus.packet_o, bus.msgtype_o, bus.format_o);
    end
    bus.packet_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.packet_ready_i = 1'b0;
    checks++;
    if (bus.packet_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_release valid=%b want 0", bus.packet_valid_o);
    end
  endtask

  task automatic test_cross_boundary();
    bit to;
    do_flush();
    stream_clear();
    add_pkt(30, rnd128());
    add_pkt(45, rnd128());
    add_pkt(127, rnd128());
    build_words();
    checks++;
    if (words_q.size() !== 7) begin
      failures++;
      $display("FAIL cross_words got=%0d want 7", words_q.size());
    end
    run_stream(500, 100, to);
    checks++;
    if (to !== 1'b0 || rx_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL cross_count timeout=%b got=%0d want %0d", to, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL cross_pkt%0d got len=%0d data=%h want len=%0d data=%h",
                 i, rx_q[i].len, rx_q[i].data, exp_q[i].len, exp_q[i].data);
      end
    end
  endtask

  task automatic test_padding();
    bit to;
    do_flush();
    stream_clear();
    add_pkt(10, rnd128());
    add_pad();
    add_pkt(20, rnd128());
    build_words();
    run_stream(500, 100, to);
    repeat (10) begin
      @(negedge clk);
      bus.packet_ready_i = 1'b1;
      if (bus.packet_valid_o) rx_q.push_back('0);
    end
    bus.packet_ready_i = 1'b0;
    checks++;
    if (to !== 1'b0 || rx_q.size() !== 2) begin
      failures++;
      $display("FAIL pad_count timeout=%b got=%0d want 2", to, rx_q.size());
    end
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL pad_pkt%0d got len=%0d data=%h want len=%0d data=%h",
                 i, rx_q[i].len, rx_q[i].data, exp_q[i].len, exp_q[i].data);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    do_flush();
    stream_clear();
    for (int i = 0; i < 12; i++) add_pkt($urandom_range(1, 5), rnd128());
    build_words();
    run_stream(500, 100, to);
    checks++;
    if (to !== 1'b0 || rx_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count timeout=%b got=%0d want %0d", to, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_pkt%0d got len=%0d msg=%0d fmt=%0d data=%h want len=%0d msg=%0d fmt=%0d data=%h",
                 i, rx_q[i].len, rx_q[i].msg, rx_q[i].fmt, rx_q[i].data,
                 exp_q[i].len, exp_q[i].msg, exp_q[i].fmt, exp_q[i].data);
      end
      if (i > 0) begin
        checks++;
        if (rx_cyc_q[i] - rx_cyc_q[i-1] !== 3) begin
          failures++;
          $display("FAIL b2b_period%0d got=%0d want 3", i, rx_cyc_q[i] - rx_cyc_q[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    bit saw_drop;
    bit have_hold;
    int acc;
    int exp_fill;
    pkt_t hold;
    pkt_t cur;
    do_flush();
    stream_clear();
    add_pkt(40, rnd128());
    for (int i = 0; i < 9; i++) add_pkt($urandom_range(60, 127), rnd128());
    build_words();
    acc = 0;
    saw_drop = 0;
    have_hold = 0;
    hold = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.packet_valid_o) begin
        // Stalled on the first packet: its header and payload are the only bits consumed.
        exp_fill = 32 * acc - 47;
        checks++;
        if (bus.word_ready_o !== 1'(exp_fill <= 128)) begin
          failures++;
          $display("FAIL bp_ready cyc=%0d got=%b want %b (fill %0d)", c, bus.word_ready_o, exp_fill <= 128, exp_fill);
        end
        cur = {bus.packet_len_o, 2'(bus.msgtype_o), bus.format_o, bus.packet_o};
        if (!have_hold) begin
          hold = cur;
          have_hold = 1;
        end else begin
          checks++;
          if (cur !== hold) begin
            failures++;
            $display("FAIL bp_stable cyc=%0d got len=%0d data=%h want len=%0d data=%h",
                     c, cur.len, cur.data, hold.len, hold.data);
          end
        end
      end
      if (!bus.word_ready_o) saw_drop = 1;
      bus.packet_ready_i = 1'b0;
      bus.word_valid_i   = (words_q.size() != 0);
      bus.word_i         = (words_q.size() != 0) ? words_q[0] : '0;
      if (bus.word_valid_i && bus.word_ready_o) begin
        acc++;
        void'(words_q.pop_front());
      end
      @(posedge clk);
    end
    checks++;
    if (saw_drop !== 1'b1 || have_hold !== 1'b1 || hold !== exp_q[0]) begin
      failures++;
      $display("FAIL bp_hold drop=%b held=%b len=%0d data=%h want 1 1 len=%0d data=%h",
               saw_drop, have_hold, hold.len, hold.data, exp_q[0].len, exp_q[0].data);
    end
    run_stream(3000, 70, to);
    checks++;
    if (to !== 1'b0 || rx_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL bp_count timeout=%b got=%0d want %0d", to, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_pkt%0d got len=%0d data=%h want len=%0d data=%h",
                 i, rx_q[i].len, rx_q[i].data, exp_q[i].len, exp_q[i].data);
      end
    end
  endtask

  // Leaves the unpacker waiting for a 100-bit payload with 40 bits buffered.
  task automatic setup_mid_payload(output bit to);
    do_flush();
    stream_clear();
    add_pkt(10, 128'h3A5);
    add_pkt(100, rnd128());
    void'(exp_q.pop_back());
    build_words();
    while (words_q.size() > 2) void'(words_q.pop_back());
    run_stream(200, 100, to);
    repeat (4) @(posedge clk);
  endtask

  task automatic test_flush();
    bit to;
    bit to2;
    setup_mid_payload(to);
    checks++;
    if (to !== 1'b0 || rx_q.size() !== 1 || rx_q[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL flush_setup timeout=%b got=%0d want 1 packet len 10", to, rx_q.size());
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (bus.word_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready_low got=%b want 0", bus.word_ready_o);
    end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (bus.packet_valid_o !== 1'b0 || bus.word_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL flush_after valid=%b ready=%b want 0 1", bus.packet_valid_o, bus.word_ready_o);
    end
    stream_clear();
    for (int i = 0; i < 3; i++) add_pkt($urandom_range(1, 127), rnd128());
    build_words();
    run_stream(800, 80, to2);
    checks++;
    if (to2 !== 1'b0 || rx_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL flush_next_count timeout=%b got=%0d want %0d", to2, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL flush_next_pkt%0d got len=%0d data=%h want len=%0d data=%h",
                 i, rx_q[i].len, rx_q[i].data, exp_q[i].len, exp_q[i].data);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit to2;
    setup_mid_payload(to);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.word_ready_o !== 1'b0 || bus.packet_valid_o !== 1'b0 || bus.packet_o !== '0 ||
        bus.packet_len_o !== '0 || bus.msgtype_o !== 2'd0 || bus.format_o !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_outputs ready=%b valid=%b pkt=%h len=%0d msg=%0d fmt=%0d want all 0",
               bus.word_ready_o, bus.packet_valid_o, bus.packet_o, bus.packet_len_o,
               bus.msgtype_o, bus.format_o);
    end
    rst_n = 1'b1;
    stream_clear();
    for (int i = 0; i < 3; i++) add_pkt($urandom_range(1, 127), rnd128());
    build_words();
    run_stream(800, 80, to2);
    checks++;
    if (to !== 1'b0 || to2 !== 1'b0 || rx_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL rstmid_next_count timeout=%b/%b got=%0d want %0d", to, to2, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rstmid_pkt%0d got len=%0d data=%h want len=%0d data=%h",
                 i, rx_q[i].len, rx_q[i].data, exp_q[i].len, exp_q[i].data);
      end
    end
  endtask

  task automatic test_random();
    bit to;
    for (int it = 0; it < 4; it++) begin
      do_flush();
      stream_clear();
      for (int i = 0; i < 15; i++) begin
        if ($urandom_range(3) == 0) add_pad();
        add_pkt($urandom_range(1, 127), rnd128());
      end
      build_words();
      run_stream(5000, $urandom_range(30, 100), to);
      checks++;
      if (to !== 1'b0 || rx_q.size() !== exp_q.size()) begin
        failures++;
        $display("FAIL rand%0d_count timeout=%b got=%0d want %0d", it, to, rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand%0d_pkt%0d got len=%0d msg=%0d fmt=%0d data=%h want len=%0d msg=%0d fmt=%0d data=%h",
                   it, i, rx_q[i].len, rx_q[i].msg, rx_q[i].fmt, rx_q[i].data,
                   exp_q[i].len, exp_q[i].msg, exp_q[i].fmt, exp_q[i].data);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_cross_boundary();
    test_padding();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
